// File: rtl/booth_r4_seq_mult_if.sv
// rtl/booth_r4_seq_mult_if.sv - start/busy/done handshake and operand/result bus for booth_r4_seq_mult
interface booth_r4_seq_mult_if #(
  parameter int W = 8
);
  logic           start;
  logic           tc;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] y;

  // controller side: issues operands and start, watches busy/done/y
  modport master (
    output start, tc, a, b,
    input  busy, done, y
  );

  // multiplier side
  modport slave (
    input  start, tc, a, b,
    output busy, done, y
  );
endinterface

// File: rtl/booth_r4_seq_mult.sv
// rtl/booth_r4_seq_mult.sv - sequential radix-4 Booth multiplier, one recoded digit per clock
module booth_r4_seq_mult #(
  parameter int W = 8
) (
  input logic               clk,
  input logic               rst,
  booth_r4_seq_mult_if.slave bus
);

  localparam int N  = W / 2 + 1;
  localparam int CW = $clog2(N + 1);

  if (((W % 2) != 0) || (W < 4)) begin : g_bad_width
    $error("booth_r4_seq_mult: W must be even and >= 4");
  end

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state;
  logic [2*W-1:0]   r_acc;
  logic [2*W-1:0]   r_m;
  logic [W+2:0]     r_q;
  logic [CW-1:0]    r_i;
  logic [2*W-1:0]   r_y;
  logic             r_busy;
  logic             r_done;

  logic             w_e;
  logic [2*W-1:0]   w_m_ext;
  logic [W+2:0]     w_q_ext;
  logic [2*W-1:0]   w_m2;
  logic [2*W-1:0]   w_addend;
  logic [2*W-1:0]   w_acc_next;
  logic             w_last;

  // Operand extension at capture: after this, tc is no longer needed because
  // both the multiplicand and the guard bits of the multiplier carry the sign.
  // Q has two guard bits above b so the final digit window {e,e,b[W-1]} exists.
  assign w_e     = bus.tc & bus.b[W-1];
  assign w_m_ext = {{W{bus.tc & bus.a[W-1]}}, bus.a};
  assign w_q_ext = {w_e, w_e, bus.b, 1'b0};

  // r_m is pre-shifted by 2 each digit, so it already equals M << 2i
  assign w_m2       = {r_m[2*W-2:0], 1'b0};
  assign w_acc_next = r_acc + w_addend;
  assign w_last     = (r_i == CW'(N - 1));

  // Booth radix-4 digit decode of the current 3-bit window
  always_comb begin
    w_addend = '0;
    case (r_q[2:0])
      3'b001, 3'b010: w_addend = r_m;
      3'b011:         w_addend = w_m2;
      3'b100:         w_addend = '0 - w_m2;
      3'b101, 3'b110: w_addend = '0 - r_m;
      default:        w_addend = '0;
    endcase
  end

  // Control FSM and datapath; all outputs come straight from registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_m     <= '0;
      r_q     <= '0;
      r_i     <= '0;
      r_y     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_m     <= w_m_ext;
            r_q     <= w_q_ext;
            r_acc   <= '0;
            r_i     <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc <= w_acc_next;
          r_m   <= {r_m[2*W-3:0], 2'b00};
          r_q   <= {{2{r_q[W+2]}}, r_q[W+2:2]};
          r_i   <= r_i + 1'b1;
          if (w_last) begin
            r_y     <= w_acc_next;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.y    = r_y;

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// tb/tb_booth_r4_seq_mult.sv - directed self-checking bench for booth_r4_seq_mult (W=8 and W=16)
module tb_booth_r4_seq_mult;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  booth_r4_seq_mult_if #(.W(8))  bus8 ();
  booth_r4_seq_mult_if #(.W(16)) bus16 ();

  booth_r4_seq_mult #(.W(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8));
  booth_r4_seq_mult #(.W(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one rising edge, land 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // full W=8 operation with fixed-latency checks: done exactly 5 edges after start
  task automatic op8(input string tag, input logic tc, input logic [7:0] a,
                     input logic [7:0] b, input logic [15:0] exp);
    bus8.tc = tc; bus8.a = a; bus8.b = b; bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    bus8.a = ~a; bus8.b = ~b; bus8.tc = ~tc;
    check({tag, ".busy0"}, 64'(bus8.busy), 64'd1);
    for (int e = 1; e <= 5; e++) begin
      step();
      check({tag, ".done"}, 64'(bus8.done), 64'(e == 5));
      check({tag, ".busy"}, 64'(bus8.busy), 64'(e != 5));
    end
    check({tag, ".y"}, 64'(bus8.y), 64'(exp));
  endtask

  // W=16 operation: done exactly 9 edges after start
  task automatic op16(input string tag, input logic tc, input logic [15:0] a,
                      input logic [15:0] b, input logic [31:0] exp);
    bus16.tc = tc; bus16.a = a; bus16.b = b; bus16.start = 1'b1;
    step();
    bus16.start = 1'b0;
    bus16.a = ~a; bus16.b = ~b;
    for (int e = 1; e <= 9; e++) begin
      step();
      check({tag, ".done"}, 64'(bus16.done), 64'(e == 9));
    end
    check({tag, ".y"}, 64'(bus16.y), 64'(exp));
  endtask

  function automatic logic [31:0] ref16(input logic tc, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] xa;
    logic [31:0] xb;
    xa = tc ? {{16{a[15]}}, a} : {16'b0, a};
    xb = tc ? {{16{b[15]}}, b} : {16'b0, b};
    return xa * xb;
  endfunction

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rtc;
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    bus8.start = 1'b0;  bus8.tc = 1'b0;  bus8.a = '0;  bus8.b = '0;
    bus16.start = 1'b0; bus16.tc = 1'b0; bus16.a = '0; bus16.b = '0;

    // 1: reset, then idle with start low
    step(); step();
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check("idle.busy", 64'(bus8.busy), 64'd0);
      check("idle.done", 64'(bus8.done), 64'd0);
      check("idle.y",    64'(bus8.y),    64'd0);
    end
    check("idle16.y", 64'(bus16.y), 64'd0);

    // 2: signed -3 * 5
    op8("m3x5", 1'b1, 8'hFD, 8'h05, 16'hFFF1);

    // 3: corner products
    op8("min_x_min", 1'b1, 8'h80, 8'h80, 16'h4000);
    op8("umax_sq",   1'b0, 8'hFF, 8'hFF, 16'hFE01);
    op8("m1_x_m1",   1'b1, 8'hFF, 8'hFF, 16'h0001);
    op8("zero",      1'b1, 8'h00, 8'h9C, 16'h0000);

    // 4: start while busy is ignored; start in the done cycle is accepted
    bus8.tc = 1'b0; bus8.a = 8'd7; bus8.b = 8'd9; bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    step();
    bus8.a = 8'd2; bus8.b = 8'd2; bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    check("busy_ign.busy", 64'(bus8.busy), 64'd1);
    step(); step();
    check("busy_ign.pre", 64'(bus8.done), 64'd0);
    step();
    check("busy_ign.done", 64'(bus8.done), 64'd1);
    check("busy_ign.y",    64'(bus8.y),    64'h003F);
    op8("b2b", 1'b0, 8'd2, 8'd2, 16'h0004);

    // 5: reset mid-operation discards it
    bus8.tc = 1'b0; bus8.a = 8'd100; bus8.b = 8'd100; bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("midrst.busy", 64'(bus8.busy), 64'd0);
    check("midrst.done", 64'(bus8.done), 64'd0);
    check("midrst.y",    64'(bus8.y),    64'd0);
    for (int k = 0; k < 6; k++) begin
      step();
      check("midrst.nodone", 64'(bus8.done), 64'd0);
    end
    op8("12x12", 1'b0, 8'd12, 8'd12, 16'h0090);

    // 6: W=16 corners and pseudo-random operands
    op16("s_max_min", 1'b1, 16'h7FFF, 16'h8000, 32'hC0008000);
    op16("s_min_min", 1'b1, 16'h8000, 16'h8000, 32'h40000000);
    op16("u_max_sq",  1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    op16("s_m1_m1",   1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001);
    op16("zero16",    1'b0, 16'h0000, 16'hFFFF, 32'h00000000);
    op16("s_1_min",   1'b1, 16'h0001, 16'h8000, 32'hFFFF8000);
    op16("u_1_min",   1'b0, 16'h0001, 16'h8000, 32'h00008000);
    op16("s_m1_max",  1'b1, 16'hFFFF, 16'h7FFF, 32'hFFFF8001);
    for (int k = 0; k < 8; k++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rtc = 1'($urandom);
      op16("rand16", rtc, ra, rb, ref16(rtc, ra, rb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
